qea_host_sequencer: RTL and testbench
=====================================

# qea_host_sequencer

Host-side sequencer for one QEA instance. It takes a context-word stream and an initial-state stream and writes them into the QEA context RAM and state RAM. It then pulses start, waits for completion under a watchdog, and streams the final state vector back out, reporting execution cycle count and error status. It sits between the system host/DMA and the QEA ports, and replaces the hand-driven load/start/readout sequence.

## Interface
- PE_NUM, 4, amplitudes per state RAM row
- STATE_DATA_WIDTH, 64, one complex amplitude (re/im, 32 bits each)
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width
- MAX_QBIT_WIDTH, 6, width of qubit-count field
- MAX_QBIT, 16, largest legal qubit count
- TIMEOUT_CYCLES, 2**24, RUN watchdog limit

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_run  in  1  one-cycle job request; ignored unless IDLE
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  number of context words; sampled on i_run
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count; sampled on i_run
- i_ctx_valid / o_ctx_ready  in/out  1  context stream handshake
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- i_st_valid / o_st_ready  in/out  1  initial-state stream handshake
- i_st_data  in  PE_NUM*STATE_DATA_WIDTH  one state row
- o_res_valid / i_res_ready  out/in  1  result stream handshake
- o_res_data  out  PE_NUM*STATE_DATA_WIDTH  one result row
- o_ctx_en, o_ctx_wea  out  1  to QEA i_ctx_en / i_ctx_wea
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  to QEA i_ctx_addr
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  to QEA i_ctx_data
- o_state_ena, o_state_wea  out  1  to QEA i_state_ena / i_state_wea
- o_state_addra  out  STATE_ADDR_WIDTH  to QEA i_state_addra
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  to QEA i_state_dina
- o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count, to QEA i_qbit_num
- o_start  out  1  to QEA i_start
- i_complete  in  1  from QEA o_complete
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  from QEA o_state_dout
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when a job finishes, normally or with an error
- o_err_qbit, o_err_timeout  out  1  sticky error flags; cleared on next accepted i_run
- o_cycle_count  out  32  RUN duration of the last job

## Operation
- States: IDLE, LOAD_CTX, LOAD_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE.
- Row count is N = 2**(qbit_num-2).
- IDLE + i_run:
  - qbit_num < 2 or > MAX_QBIT -> DONE with o_err_qbit=1; nothing is written.
  - else latch operands and go to LOAD_CTX; if ins_num==0, go directly to LOAD_STATE.
- LOAD_CTX:
  - o_ctx_ready=1.
  - Each accepted beat k drives en=wea=1, addr=k, data for one cycle.
  - After beat ins_num-1 -> LOAD_STATE.
- LOAD_STATE:
  - o_st_ready=1.
  - Accepted row r drives ena=wea=1, addra=r for one cycle.
  - After row N-1 -> START.
- START: o_start=1 for exactly one cycle, then RUN.
- RUN:
  - The cycle counter increments every cycle.
  - i_complete=1 -> RD_REQ.
  - Counter reaching TIMEOUT_CYCLES -> DONE with o_err_timeout=1; no readout.
- Readout loop, per row:
  - RD_REQ: ena=1, wea=0, addra=row.
  - RD_WAIT: absorbs the 1-cycle RAM latency; i_state_dout is captured into a holding register at the end of this cycle.
  - RD_OUT: o_res_valid=1 until i_res_ready. After row N-1 -> DONE; else -> RD_REQ.
- DONE: o_done=1 for one cycle, then IDLE.
- Width rules: addresses wrap modulo 2**width; ins_num is bounded by the port width, so no overflow handling is needed. o_cycle_count saturates at 2**32-1.

## Timing
- All outputs are registered.
- Reset value of every output is 0, except o_qbit_num, which resets to 0 and holds its latched value after reset.
- RAM write ports assert in cycle t+1 for a beat accepted in cycle t.
- Readout rate: one row per 3 cycles with i_res_ready tied high.
- o_cycle_count = cycles from the o_start cycle (counted as 1) through the cycle i_complete is sampled high. It is updated on the RUN exit and stable from DONE onward.
- i_complete is ignored outside RUN.
- i_run while busy is dropped; no queuing.
- Stream valid low stalls the FSM indefinitely; there is no load timeout.
- Reset mid-job returns to IDLE next cycle with all RAM enables low. RAM contents are undefined afterwards; the QEA needs its own reset.

## Structure
- Shared package qea_host_pkg holds:
  - the state enum
  - RAM_RD_LATENCY = 1
  - CYCLE_CNT_WIDTH = 32
- Single module, no sub-modules; the readout holding register is inline.

## Test plan
- qbit_num=6, ins_num=183, streams always valid, i_res_ready=1:
  - 183 ctx writes, addr 0..182
  - 16 state writes
  - one o_start pulse
  - 16 result rows, row0 = {64'h40000000_00000000, 0, 0, 0}
  - o_done pulse, both error flags 0
- i_complete stub fires 50 cycles after o_start -> o_cycle_count=51.
- i_res_ready toggled 1/0 on alternate cycles -> 16 rows, none duplicated or dropped, in address order.
- qbit_num=1 -> o_done next cycle, o_err_qbit=1, no RAM enables; the next valid i_run clears the flag.
- i_complete never asserts with TIMEOUT_CYCLES=100 -> o_err_timeout=1, o_done pulse, no readout.
- rst asserted mid-LOAD_STATE -> next cycle IDLE, all outputs 0; a new i_run then completes normally.

Source files
------------

// File: rtl/qea_host_pkg.sv
// Shared constants and FSM state type for the QEA host sequencer.
package qea_host_pkg;

  localparam int unsigned RAM_RD_LATENCY  = 1;
  localparam int unsigned CYCLE_CNT_WIDTH = 32;
  localparam int unsigned RD_WAIT_WIDTH   = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CTX,
    ST_LOAD_STATE,
    ST_START,
    ST_RUN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/qea_host_sequencer.sv
// Host-side load/start/readout sequencer for one QEA instance.
// Streams context and initial state into the QEA RAMs, runs under a watchdog, then streams the result back.
module qea_host_sequencer
  import qea_host_pkg::*;
#(
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned MAX_QBIT                = 16,
  parameter int unsigned TIMEOUT_CYCLES          = 2**24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_run,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_st_valid,
  output logic                                 o_st_ready,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_data,
  output logic                                 o_res_valid,
  input  logic                                 i_res_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err_qbit,
  output logic                                 o_err_timeout,
  output logic [CYCLE_CNT_WIDTH-1:0]           o_cycle_count
);

  localparam int unsigned ROW_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned CA_W  = GATE_CONTEXT_ADDR_WIDTH;
  localparam int unsigned CD_W  = GATE_CONTEXT_DATA_WIDTH;
  localparam int unsigned SA_W  = STATE_ADDR_WIDTH;
  localparam int unsigned QB_W  = MAX_QBIT_WIDTH;
  localparam int unsigned CC_W  = CYCLE_CNT_WIDTH;

  seq_state_e             state_q, state_d;
  logic [CA_W-1:0]        ins_num_q, ins_num_d;
  logic [SA_W-1:0]        last_row_q, last_row_d;
  logic [CA_W-1:0]        ctx_cnt_q, ctx_cnt_d;
  logic [SA_W-1:0]        row_q, row_d;
  logic [CC_W-1:0]        run_cnt_q, run_cnt_d;
  logic [RD_WAIT_WIDTH-1:0] wait_q, wait_d;

  logic                   ctx_ready_q, ctx_ready_d;
  logic                   st_ready_q, st_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic [ROW_W-1:0]       res_data_q, res_data_d;
  logic                   ctx_en_q, ctx_en_d;
  logic                   ctx_wea_q, ctx_wea_d;
  logic [CA_W-1:0]        ctx_addr_q, ctx_addr_d;
  logic [CD_W-1:0]        ctx_data_q, ctx_data_d;
  logic                   state_ena_q, state_ena_d;
  logic                   state_wea_q, state_wea_d;
  logic [SA_W-1:0]        state_addra_q, state_addra_d;
  logic [ROW_W-1:0]       state_dina_q, state_dina_d;
  logic [QB_W-1:0]        qbit_num_q, qbit_num_d;
  logic                   start_q, start_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_qbit_q, err_qbit_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [CC_W-1:0]        cycle_count_q, cycle_count_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    ins_num_d     = ins_num_q;
    last_row_d    = last_row_q;
    ctx_cnt_d     = ctx_cnt_q;
    row_d         = row_q;
    run_cnt_d     = run_cnt_q;
    wait_d        = wait_q;
    res_data_d    = res_data_q;
    ctx_en_d      = 1'b0;
    ctx_wea_d     = 1'b0;
    ctx_addr_d    = ctx_addr_q;
    ctx_data_d    = ctx_data_q;
    state_ena_d   = 1'b0;
    state_wea_d   = 1'b0;
    state_addra_d = state_addra_q;
    state_dina_d  = state_dina_q;
    qbit_num_d    = qbit_num_q;
    err_qbit_d    = err_qbit_q;
    err_timeout_d = err_timeout_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          err_qbit_d    = 1'b0;
          err_timeout_d = 1'b0;
          cycle_count_d = '0;
          if ((32'(i_qbit_num) < 32'd2) || (32'(i_qbit_num) > MAX_QBIT)) begin
            err_qbit_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            qbit_num_d = i_qbit_num;
            ins_num_d  = i_ins_num;
            last_row_d = SA_W'((32'd1 << (i_qbit_num - QB_W'(2))) - 32'd1);
            ctx_cnt_d  = '0;
            row_d      = '0;
            state_d    = (i_ins_num == '0) ? ST_LOAD_STATE : ST_LOAD_CTX;
          end
        end
      end
      ST_LOAD_CTX: begin
        if (ctx_ready_q && i_ctx_valid) begin
          ctx_en_d   = 1'b1;
          ctx_wea_d  = 1'b1;
          ctx_addr_d = ctx_cnt_q;
          ctx_data_d = i_ctx_data;
          ctx_cnt_d  = ctx_cnt_q + CA_W'(1);
          if (ctx_cnt_q == ins_num_q - CA_W'(1)) state_d = ST_LOAD_STATE;
        end
      end
      ST_LOAD_STATE: begin
        if (st_ready_q && i_st_valid) begin
          state_ena_d   = 1'b1;
          state_wea_d   = 1'b1;
          state_addra_d = row_q;
          state_dina_d  = i_st_data;
          row_d         = row_q + SA_W'(1);
          if (row_q == last_row_q) begin
            row_d   = '0;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        run_cnt_d = CC_W'(1);
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        // Saturating count; the o_start cycle already counted as 1
        run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CC_W'(1);
        if (i_complete) begin
          cycle_count_d = run_cnt_d;
          state_d       = ST_RD_REQ;
        end else if (run_cnt_d >= CC_W'(TIMEOUT_CYCLES)) begin
          cycle_count_d = run_cnt_d;
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        wait_d  = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_q == RD_WAIT_WIDTH'(RAM_RD_LATENCY - 1)) begin
          res_data_d = i_state_dout;
          state_d    = ST_RD_OUT;
        end else begin
          wait_d = wait_q + RD_WAIT_WIDTH'(1);
        end
      end
      ST_RD_OUT: begin
        if (i_res_ready) begin
          if (row_q == last_row_q) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + SA_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Read port is driven in the cycle the FSM sits in RD_REQ
    if (state_d == ST_RD_REQ) begin
      state_ena_d   = 1'b1;
      state_wea_d   = 1'b0;
      state_addra_d = row_d;
    end

    ctx_ready_d = (state_d == ST_LOAD_CTX);
    st_ready_d  = (state_d == ST_LOAD_STATE);
    start_d     = (state_d == ST_START);
    res_valid_d = (state_d == ST_RD_OUT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ins_num_q     <= '0;
      last_row_q    <= '0;
      ctx_cnt_q     <= '0;
      row_q         <= '0;
      run_cnt_q     <= '0;
      wait_q        <= '0;
      ctx_ready_q   <= 1'b0;
      st_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      ctx_en_q      <= 1'b0;
      ctx_wea_q     <= 1'b0;
      ctx_addr_q    <= '0;
      ctx_data_q    <= '0;
      state_ena_q   <= 1'b0;
      state_wea_q   <= 1'b0;
      state_addra_q <= '0;
      state_dina_q  <= '0;
      qbit_num_q    <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_qbit_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ins_num_q     <= ins_num_d;
      last_row_q    <= last_row_d;
      ctx_cnt_q     <= ctx_cnt_d;
      row_q         <= row_d;
      run_cnt_q     <= run_cnt_d;
      wait_q        <= wait_d;
      ctx_ready_q   <= ctx_ready_d;
      st_ready_q    <= st_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      ctx_en_q      <= ctx_en_d;
      ctx_wea_q     <= ctx_wea_d;
      ctx_addr_q    <= ctx_addr_d;
      ctx_data_q    <= ctx_data_d;
      state_ena_q   <= state_ena_d;
      state_wea_q   <= state_wea_d;
      state_addra_q <= state_addra_d;
      state_dina_q  <= state_dina_d;
      qbit_num_q    <= qbit_num_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_qbit_q    <= err_qbit_d;
      err_timeout_q <= err_timeout_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign o_ctx_ready   = ctx_ready_q;
  assign o_st_ready    = st_ready_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_data    = res_data_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_wea_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = state_ena_q;
  assign o_state_wea   = state_wea_q;
  assign o_state_addra = state_addra_q;
  assign o_state_dina  = state_dina_q;
  assign o_qbit_num    = qbit_num_q;
  assign o_start       = start_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err_qbit    = err_qbit_q;
  assign o_err_timeout = err_timeout_q;
  assign o_cycle_count = cycle_count_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a QEA stub (state RAM, 1-cycle read latency, completion timer).
module tb_qea_host_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_run = 1'b0;
  logic [15:0]  i_ins_num = '0;
  logic [5:0]   i_qbit_num = '0;
  logic         i_ctx_valid = 1'b0;
  logic         o_ctx_ready;
  logic [63:0]  i_ctx_data = '0;
  logic         i_st_valid = 1'b0;
  logic         o_st_ready;
  logic [255:0] i_st_data = '0;
  logic         o_res_valid;
  logic         i_res_ready = 1'b1;
  logic [255:0] o_res_data;
  logic         o_ctx_en, o_ctx_wea;
  logic [15:0]  o_ctx_addr;
  logic [63:0]  o_ctx_data;
  logic         o_state_ena, o_state_wea;
  logic [15:0]  o_state_addra;
  logic [255:0] o_state_dina;
  logic [5:0]   o_qbit_num;
  logic         o_start;
  logic         i_complete = 1'b0;
  logic [255:0] i_state_dout = '0;
  logic         o_busy, o_done, o_err_qbit, o_err_timeout;
  logic [31:0]  o_cycle_count;

  qea_host_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_ins_num(i_ins_num), .i_qbit_num(i_qbit_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_data(i_st_data),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_qbit_num(o_qbit_num), .o_start(o_start),
    .i_complete(i_complete), .i_state_dout(i_state_dout), .o_busy(o_busy), .o_done(o_done),
    .o_err_qbit(o_err_qbit), .o_err_timeout(o_err_timeout), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Job mode, written only by the main sequence
  int job_seq    = 0;
  int cpl_delay  = 50;
  bit res_toggle = 1'b0;
  bit st_gap     = 1'b0;

  // Monitor state, written only by the negedge monitor
  int seen_seq = 0;
  int ctx_idx, st_idx, n_ctx_wr, n_st_wr, n_rd, n_res, n_start, n_done;
  int tick = -1;
  int cyc = 0;
  int res_first, res_last;
  bit rd_pend = 1'b0;
  logic [5:0]   rd_addr = '0;
  logic [255:0] mem [0:63];
  logic [255:0] junk = {8{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ctx_word(input int k);
    return {16'hC7C7, 16'(k), 32'(k) * 32'h9E3779B1};
  endfunction

  function automatic logic [255:0] st_row(input int r);
    logic [255:0] v;
    if (r == 0) v = {64'h40000000_00000000, 192'd0};
    else v = {32'hA5A50000 | 32'(r), 32'(r), 64'(r * 3), 64'(r * 5 + 1), 64'(r) ^ 64'hFFFF};
    return v;
  endfunction

  // Stream sources, QEA stub and write/result monitors
  always @(negedge clk) begin
    cyc++;
    if (seen_seq != job_seq) begin
      seen_seq = job_seq;
      ctx_idx = 0; st_idx = 0; n_ctx_wr = 0; n_st_wr = 0; n_rd = 0;
      n_res = 0; n_start = 0; n_done = 0; tick = -1; res_first = 0; res_last = 0;
    end
    i_state_dout = rd_pend ? mem[rd_addr] : junk;
    rd_pend = o_state_ena && !o_state_wea;
    rd_addr = o_state_addra[5:0];
    if (o_state_ena && !o_state_wea) n_rd++;
    if (o_state_ena && o_state_wea) begin
      check("st_addr", 256'(o_state_addra), 256'(16'(n_st_wr)));
      check("st_data", o_state_dina, st_row(n_st_wr));
      mem[o_state_addra[5:0]] = o_state_dina;
      n_st_wr++;
    end
    if (o_ctx_en) begin
      check("ctx_wea", 256'(o_ctx_wea), 256'(1'b1));
      check("ctx_addr", 256'(o_ctx_addr), 256'(16'(n_ctx_wr)));
      check("ctx_data", 256'(o_ctx_data), 256'(ctx_word(n_ctx_wr)));
      n_ctx_wr++;
    end
    if (o_start) begin n_start++; tick = 0; end
    else if (tick >= 0) tick++;
    i_complete = (cpl_delay >= 0) && (tick == cpl_delay);
    if (o_done) n_done++;
    i_res_ready = res_toggle ? ~i_res_ready : 1'b1;
    if (o_res_valid && i_res_ready) begin
      check("res_row", o_res_data, st_row(n_res));
      if (n_res == 0) res_first = cyc;
      res_last = cyc;
      n_res++;
    end
    i_ctx_valid = 1'b1;
    i_ctx_data  = ctx_word(ctx_idx);
    if (o_ctx_ready && i_ctx_valid) ctx_idx++;
    i_st_valid = st_gap ? ~i_st_valid : 1'b1;
    i_st_data  = st_row(st_idx);
    if (o_st_ready && i_st_valid) st_idx++;
  end

  task automatic run_job(input logic [5:0] q, input logic [15:0] ins, input int cpl, input bit tog, input bit gap);
    @(negedge clk);
    cpl_delay = cpl; res_toggle = tog; st_gap = gap; job_seq++;
    @(negedge clk);
    i_qbit_num = q; i_ins_num = ins; i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && o_done !== 1'b1; i++) @(negedge clk);
    check(tag, 256'(o_done), 256'(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 256'({o_ctx_ready, o_st_ready, o_res_valid, o_ctx_en, o_ctx_wea, o_state_ena,
                              o_state_wea, o_start, o_busy, o_done, o_err_qbit, o_err_timeout}), 256'(0));
    check({tag, "_bus"}, 256'({o_ctx_addr, o_state_addra, o_qbit_num, o_cycle_count}), 256'(0));
    check({tag, "_ctxd"}, 256'(o_ctx_data), 256'(0));
    check({tag, "_dina"}, o_state_dina, 256'(0));
    check({tag, "_res"}, o_res_data, 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Job 1: 6 qubits, 183 context words, everything free-flowing
    run_job(6'd6, 16'd183, 50, 1'b0, 1'b0);
    check("j1_busy", 256'(o_busy), 256'(1'b1));
    wait_done("j1_done", 2000);
    check("j1_errs", 256'({o_err_qbit, o_err_timeout}), 256'(0));
    check("j1_cycles", 256'(o_cycle_count), 256'(32'd51));
    check("j1_qbit", 256'(o_qbit_num), 256'(6'd6));
    repeat (2) @(negedge clk);
    check("j1_ctx_n", 256'(n_ctx_wr), 256'(183));
    check("j1_st_n", 256'(n_st_wr), 256'(16));
    check("j1_start_n", 256'(n_start), 256'(1));
    check("j1_rd_n", 256'(n_rd), 256'(16));
    check("j1_res_n", 256'(n_res), 256'(16));
    check("j1_done_n", 256'(n_done), 256'(1));
    check("j1_rate", 256'(res_last - res_first), 256'(45));
    check("j1_idle", 256'(o_busy), 256'(1'b0));

    // Job 2: backpressured result, gappy state stream, dropped i_run while busy
    run_job(6'd6, 16'd5, 50, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    i_qbit_num = 6'd3; i_ins_num = 16'd1; i_run = 1'b1;
    @(negedge clk);
    i_run = 1'b0;
    check("j2_qbit_hold", 256'(o_qbit_num), 256'(6'd6));
    wait_done("j2_done", 2000);
    check("j2_cycles", 256'(o_cycle_count), 256'(32'd51));
    repeat (2) @(negedge clk);
    check("j2_ctx_n", 256'(n_ctx_wr), 256'(5));
    check("j2_st_n", 256'(n_st_wr), 256'(16));
    check("j2_res_n", 256'(n_res), 256'(16));
    check("j2_done_n", 256'(n_done), 256'(1));

    // Job 3: illegal qubit count 1
    run_job(6'd1, 16'd5, 50, 1'b0, 1'b0);
    check("q1_done", 256'({o_done, o_err_qbit, o_busy}), 256'(3'b111));
    @(negedge clk);
    check("q1_after", 256'({o_done, o_err_qbit, o_busy}), 256'(3'b010));
    repeat (2) @(negedge clk);
    check("q1_no_ram", 256'(n_ctx_wr + n_st_wr + n_rd + n_start), 256'(0));
    check("q1_qbit_hold", 256'(o_qbit_num), 256'(6'd6));

    // Job 4: smallest legal job, no context words; clears the qubit error
    run_job(6'd2, 16'd0, 50, 1'b0, 1'b0);
    check("j4_clr", 256'({o_err_qbit, o_busy}), 256'(2'b01));
    wait_done("j4_done", 500);
    check("j4_cycles", 256'(o_cycle_count), 256'(32'd51));
    repeat (2) @(negedge clk);
    check("j4_ctx_n", 256'(n_ctx_wr), 256'(0));
    check("j4_st_n", 256'(n_st_wr), 256'(1));
    check("j4_res_n", 256'(n_res), 256'(1));

    // Job 5: qubit count just above the limit
    run_job(6'd17, 16'd2, 50, 1'b0, 1'b0);
    check("q17_done", 256'({o_done, o_err_qbit}), 256'(2'b11));

    // Job 6: completion never arrives
    run_job(6'd3, 16'd2, -1, 1'b0, 1'b0);
    check("to_qclr", 256'(o_err_qbit), 256'(1'b0));
    wait_done("to_done", 400);
    check("to_errs", 256'({o_err_qbit, o_err_timeout}), 256'(2'b01));
    repeat (2) @(negedge clk);
    check("to_no_rd", 256'(n_rd + n_res), 256'(0));
    check("to_start_n", 256'(n_start), 256'(1));
    check("to_done_n", 256'(n_done), 256'(1));

    // Job 7: reset in the middle of the state load, then a clean job
    run_job(6'd5, 16'd3, 50, 1'b0, 1'b0);
    check("j7_toclr", 256'(o_err_timeout), 256'(1'b0));
    for (int i = 0; i < 100 && n_st_wr < 3; i++) @(negedge clk);
    check("j7_reach", 256'(n_st_wr >= 3), 256'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    run_job(6'd4, 16'd7, 50, 1'b1, 1'b1);
    wait_done("j8_done", 1000);
    check("j8_stat", 256'({o_err_qbit, o_err_timeout, o_cycle_count}), 256'({2'b00, 32'd51}));
    repeat (2) @(negedge clk);
    check("j8_ctx_n", 256'(n_ctx_wr), 256'(7));
    check("j8_st_n", 256'(n_st_wr), 256'(4));
    check("j8_res_n", 256'(n_res), 256'(4));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
